// File: rtl/mul_operand_sequencer_pkg.sv
// Shared types and widths for the Booth-multiplier operand sequencer.
package mul_operand_sequencer_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_operand_sequencer_op_fifo.sv
// Operand FIFO: registered storage, no bypass; a push into an empty FIFO
// becomes visible at the head on the following cycle.
module mul_operand_sequencer_op_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == LVL_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: storage is deliberately left out of reset; the count gates every read,
    // so stale entries are never observed and the array can map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds one operand pair at a time to the 4-bit Booth multiplier, waits its
// fixed latency and returns the product with its tag on a valid/ready port.
module mul_operand_sequencer
    import mul_operand_sequencer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_x,
    input  logic [OP_W-1:0]        in_y,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PROD_W-1:0]      out_p,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [OP_W-1:0]        mul_x,
    output logic [OP_W-1:0]        mul_y,
    output logic                   mul_en,
    input  logic [PROD_W-1:0]      mul_p
);

    localparam int FIFO_W = 2 * OP_W + TAG_W;
    localparam int CNT_W  = $clog2(MUL_LAT);

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FIFO_W-1:0] w_fifo_head;
    logic              w_pop;
    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [TAG_W-1:0]  r_tag;
    logic [OP_W-1:0]   r_mul_x;
    logic [OP_W-1:0]   r_mul_y;
    logic              r_out_valid;
    logic [PROD_W-1:0] r_out_p;
    logic [TAG_W-1:0]  r_out_tag;

    mul_operand_sequencer_op_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (FIFO_W)
    ) u_op_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid && in_ready),
        .i_data  ({in_tag, in_x, in_y}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty && (!r_out_valid || out_ready)) begin
                    w_pop        = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE:   w_next_state = S_WAIT;
            S_WAIT:    if (r_wait_cnt == '0) w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values, whatever order the simulator runs the processes in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operands stay frozen from issue through capture; only a pop reloads them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag       <= '0;
            r_mul_x     <= '0;
            r_mul_y     <= '0;
            r_wait_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_tag   <= '0;
        end else begin
            if (w_pop) begin
                {r_tag, r_mul_x, r_mul_y} <= w_fifo_head;
            end
            case (r_state)
                S_ISSUE: r_wait_cnt <= CNT_W'(MUL_LAT - 2);
                S_WAIT:  if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                default: r_wait_cnt <= r_wait_cnt;
            endcase
            if (r_state == S_CAPTURE) begin
                r_out_valid <= 1'b1;
                r_out_p     <= mul_p;
                r_out_tag   <= r_tag;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = !w_fifo_full;
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_tag   = r_out_tag;
    assign mul_x     = r_mul_x;
    assign mul_y     = r_mul_y;
    assign mul_en    = (r_state == S_ISSUE);
    assign busy      = !w_fifo_empty || (r_state != S_IDLE) || r_out_valid;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Directed bench for mul_operand_sequencer with a behavioural multiplier model.
module tb_mul_operand_sequencer;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int MUL_LAT = 10;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int NVEC    = 8;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] tag;
        logic [7:0] p;
    } vec_t;

    typedef struct packed {
        logic [7:0] p;
        logic [3:0] tag;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_x;
    logic [3:0]       in_y;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_p;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;
    logic [3:0]       mul_x;
    logic [3:0]       mul_y;
    logic             mul_en;
    logic [7:0]       mul_p;

    vec_t vecs [NVEC];
    res_t exp_q [$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_results = 0;
    int   cyc       = 0;
    int   en_cnt    = 0;
    int   stab_err  = 0;

    mul_operand_sequencer #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .out_tag    (out_tag),
        .busy       (busy),
        .fifo_level (fifo_level),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_en     (mul_en),
        .mul_p      (mul_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] ea;
        logic signed [7:0] eb;
        ea = {{4{a[3]}}, a};
        eb = {{4{b[3]}}, b};
        return ea * eb;
    endfunction

    // Multiplier model: garbage until MUL_LAT cycles after the en cycle.
    int         m_cnt;
    logic [7:0] m_prod;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_p  <= 8'h00;
            m_cnt  <= 0;
            m_prod <= 8'h00;
        end else if (mul_en) begin
            mul_p  <= 8'h5A;
            m_cnt  <= MUL_LAT - 1;
            m_prod <= smul(mul_x, mul_y);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) mul_p <= m_prod;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result scoreboard, operand-stability and en-pulse monitors.
    logic       inflight = 1'b0;
    logic       prev_ov  = 1'b0;
    logic [3:0] hx, hy;
    res_t       r_got;
    always @(negedge clk) begin
        if (mul_en) en_cnt++;
        if (rst) begin
            inflight = 1'b0;
        end else if (mul_en) begin
            inflight = 1'b1;
            hx = mul_x;
            hy = mul_y;
        end else if (inflight) begin
            if (mul_x !== hx || mul_y !== hy) stab_err++;
            if (out_valid && !prev_ov) inflight = 1'b0;
        end
        prev_ov = out_valid;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {31'd0, out_valid}, 32'd0);
            end else begin
                r_got = exp_q.pop_front();
                check("result_p", {24'd0, out_p}, {24'd0, r_got.p});
                check("result_tag", {28'd0, out_tag}, {28'd0, r_got.tag});
                n_results++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input vec_t v);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check("push_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_x     = v.x;
        in_y     = v.y;
        in_tag   = v.tag;
        exp_q.push_back('{p: v.p, tag: v.tag});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (out_valid) break;
            tick();
        end
        check("wait_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (!busy) break;
            tick();
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        vecs[0] = '{x: 4'h3, y: 4'hE, tag: 4'h5, p: 8'hFA};
        vecs[1] = '{x: 4'h7, y: 4'h7, tag: 4'h1, p: 8'h31};
        vecs[2] = '{x: 4'h7, y: 4'h8, tag: 4'h2, p: 8'hC8};
        vecs[3] = '{x: 4'hF, y: 4'hF, tag: 4'h3, p: 8'h01};
        vecs[4] = '{x: 4'h0, y: 4'h5, tag: 4'h4, p: 8'h00};
        vecs[5] = '{x: 4'hD, y: 4'h4, tag: 4'h6, p: 8'hF4};
        vecs[6] = '{x: 4'h9, y: 4'h9, tag: 4'h7, p: 8'h31};
        vecs[7] = '{x: 4'h5, y: 4'hF, tag: 4'h8, p: 8'hFB};

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_tag = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mul_en", {31'd0, mul_en}, 32'd0);
        check("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
        check("rst_out_p", {24'd0, out_p}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Single operations into an idle block: latency, one en pulse, result.
        for (int i = 0; i < NVEC; i++) begin
            wait_idle(50);
            en_cnt = 0;
            push(vecs[i]);
            acc = cyc;
            wait_valid(40);
            check("latency", cyc - acc, MUL_LAT + 2);
            wait_idle(50);
            check("en_pulses", en_cnt, 1);
        end

        // Back-to-back pushes fill the FIFO; the extra one waits for space.
        wait_idle(50);
        en_cnt = 0;
        for (int i = 0; i < DEPTH + 1; i++) push(vecs[i]);
        check("full_level", {29'd0, fifo_level}, DEPTH);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        push(vecs[DEPTH + 1]);
        wait_idle(300);
        check("full_en_pulses", en_cnt, DEPTH + 2);

        // Back-pressure: first result held, second not issued until accepted.
        out_ready = 1'b0;
        push(vecs[2]);
        push(vecs[3]);
        wait_valid(40);
        en_cnt = 0;
        repeat (20) tick();
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_p", {24'd0, out_p}, {24'd0, vecs[2].p});
        check("hold_tag", {28'd0, out_tag}, {28'd0, vecs[2].tag});
        check("hold_no_issue", en_cnt, 0);
        check("hold_level", {29'd0, fifo_level}, 32'd1);
        out_ready = 1'b1;
        wait_idle(60);
        check("hold_resume_en", en_cnt, 1);

        // Pushes while the first op is waiting must not disturb mul_x/mul_y.
        push(vecs[2]);
        repeat (3) tick();
        push(vecs[6]);
        push(vecs[7]);
        check("wait_level", {29'd0, fifo_level}, 32'd2);
        check("wait_mul_x", {28'd0, mul_x}, {28'd0, vecs[2].x});
        check("wait_mul_y", {28'd0, mul_y}, {28'd0, vecs[2].y});
        wait_idle(100);
        check("operands_stable", stab_err, 0);

        // Reset during S_WAIT with three pairs queued.
        for (int i = 1; i < 5; i++) push(vecs[i]);
        tick(); tick();
        check("pre_rst_level", {29'd0, fifo_level}, 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_p", {24'd0, out_p}, 32'd0);
        check("mid_rst_out_tag", {28'd0, out_tag}, 32'd0);
        check("mid_rst_mul_x", {28'd0, mul_x}, 32'd0);
        check("mid_rst_mul_y", {28'd0, mul_y}, 32'd0);
        check("mid_rst_mul_en", {31'd0, mul_en}, 32'd0);
        check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        en_cnt = 0;
        push(vecs[5]);
        acc = cyc;
        wait_valid(40);
        check("post_rst_latency", cyc - acc, MUL_LAT + 2);
        wait_idle(50);
        check("post_rst_en", en_cnt, 1);

        check("queue_drained", exp_q.size(), 0);
        check("result_count", n_results, NVEC + (DEPTH + 2) + 2 + 3 + 1);
        check("operands_stable_final", stab_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
